// File: rtl/mem_dma_pkg.sv
// Shared definitions for the mem_dma word-copy engine: register map, control bits,
// master FSM state encoding and small address helpers.
package mem_dma_pkg;

  localparam logic [31:0] DMA_BASE = 32'h8000_0010;

  // Register index = slave byte offset [3:2]
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  localparam int STATUS_ERR  = 2;

  localparam logic [3:0] WSTRB_READ  = 4'h0;
  localparam logic [3:0] WSTRB_WRITE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_GAP,
    ST_WR_REQ,
    ST_WR_GAP
  } state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_dma.sv
// Word-copy DMA engine: a 4-register slave port for configuration plus a second
// initiator on the picorv32 native memory bus that copies LEN words from SRC to DST.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        dma_sel,
  input  logic [3:0]  wstrb,
  input  logic [3:0]  addr,
  input  logic [31:0] dma_data_i,
  output logic        dma_ready,
  output logic [31:0] dma_data_o,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        irq
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e               state;
  logic [31:0]          src;
  logic [31:0]          dst;
  logic [31:0]          buffer;
  logic [LEN_WIDTH-1:0] len;
  logic                 done;
  logic                 err;
  logic [TW-1:0]        tmo_cnt;
  logic                 busy;

  logic        reg_wr;
  logic        wr_src;
  logic        wr_dst;
  logic        wr_len;
  logic        wr_ctrl;
  logic        ctrl_start;
  logic        ctrl_clear;
  logic        rd_hit;
  logic [31:0] rd_mux;

  assign busy = (state != ST_IDLE);
  assign irq  = done;

  // Register writes land on the ready cycle; unaligned offsets are unmapped.
  assign reg_wr     = dma_sel && dma_ready && (wstrb != 4'h0) && (addr[1:0] == 2'b00);
  assign wr_src     = reg_wr && (addr[3:2] == REG_SRC);
  assign wr_dst     = reg_wr && (addr[3:2] == REG_DST);
  assign wr_len     = reg_wr && (addr[3:2] == REG_LEN);
  assign wr_ctrl    = reg_wr && (addr[3:2] == REG_CTRL);
  assign ctrl_start = wr_ctrl && dma_data_i[CTRL_START];
  assign ctrl_clear = wr_ctrl && dma_data_i[CTRL_CLEAR];
  assign rd_hit     = dma_sel && !dma_ready;

  // NOTE: default first so every path assigns rd_mux and no latch is inferred.
  always_comb begin
    rd_mux = '0;
    if (addr[1:0] == 2'b00) begin
      case (addr[3:2])
        REG_SRC:  rd_mux = src;
        REG_DST:  rd_mux = dst;
        REG_LEN:  rd_mux = 32'(len);
        REG_CTRL: rd_mux = {29'b0, err, done, busy};
        default:  rd_mux = '0;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments with the reset sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dma_ready  <= 1'b0;
      dma_data_o <= '0;
    end else begin
      dma_ready  <= rd_hit;
      dma_data_o <= rd_hit ? rd_mux : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      src     <= '0;
      dst     <= '0;
      len     <= '0;
      buffer  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      tmo_cnt <= '0;
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
    end else begin
      if (ctrl_clear) begin
        done <= 1'b0;
        err  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (wr_src) src <= word_align(dma_data_i);
          if (wr_dst) dst <= word_align(dma_data_i);
          if (wr_len) len <= dma_data_i[LEN_WIDTH-1:0];
          if (ctrl_start) begin
            err <= 1'b0;
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              done    <= 1'b0;
              state   <= ST_RD_REQ;
              m_valid <= 1'b1;
              m_addr  <= src;
              m_wstrb <= WSTRB_READ;
              tmo_cnt <= '0;
            end
          end
        end

        ST_RD_REQ: begin
          if (m_ready) begin
            buffer  <= m_rdata;
            m_valid <= 1'b0;
            state   <= ST_RD_GAP;
          end else if (tmo_cnt == TO_LAST) begin
            m_valid <= 1'b0;
            err     <= 1'b1;
            done    <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_RD_GAP: begin
          m_valid <= 1'b1;
          m_addr  <= dst;
          m_wdata <= buffer;
          m_wstrb <= WSTRB_WRITE;
          tmo_cnt <= '0;
          state   <= ST_WR_REQ;
        end

        ST_WR_REQ: begin
          if (m_ready) begin
            src     <= src + 32'd4;
            dst     <= dst + 32'd4;
            len     <= len - 1'b1;
            m_valid <= 1'b0;
            state   <= ST_WR_GAP;
          end else if (tmo_cnt == TO_LAST) begin
            m_valid <= 1'b0;
            err     <= 1'b1;
            done    <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_WR_GAP: begin
          if (len != '0) begin
            m_valid <= 1'b1;
            m_addr  <= src;
            m_wstrb <= WSTRB_READ;
            tmo_cnt <= '0;
            state   <= ST_RD_REQ;
          end else begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Randomised bench for mem_dma: a latency-configurable memory model on the master port
// and a reference copy model that predicts the write stream and final register values.
module tb_mem_dma;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        dma_sel = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] dma_data_i = '0;
  logic        dma_ready;
  logic [31:0] dma_data_o;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        irq;

  int total = 0;
  int bad = 0;

  mem_dma #(.LEN_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn), .dma_sel(dma_sel), .wstrb(wstrb), .addr(addr),
    .dma_data_i(dma_data_i), .dma_ready(dma_ready), .dma_data_o(dma_data_o),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  // Memory model: acks (cur_lat+1) cycles after valid, optionally withholds one read.
  logic [31:0] mem [0:1023];
  logic [31:0] seed = 32'h1234_5678;
  int          lat_max = 0;
  int          stall_at = -1;
  int          rd_acks = 0;
  int          cur_lat = 0;
  int          wait_cnt = 0;
  int          vcyc = 0;
  int          run = 0;
  int          last_run = 0;
  logic        stable_err = 1'b0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_a = '0;
  logic [31:0] prev_d = '0;
  logic [3:0]  prev_s = '0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always @(posedge clk) begin
    if (!resetn) begin
      m_ready  <= 1'b0;
      m_rdata  <= '0;
      wait_cnt <= 0;
      cur_lat  <= 0;
      run      <= 0;
      prev_pend <= 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] <= seed ^ (32'(i) * 32'h9E37_79B1);
    end else begin
      vcyc <= vcyc + (m_valid ? 1 : 0);
      if (m_valid) run <= run + 1;
      else if (run != 0) begin
        last_run <= run;
        run <= 0;
      end
      if (prev_pend && m_valid &&
          (m_addr != prev_a || m_wstrb != prev_s || (m_wstrb == 4'hF && m_wdata != prev_d)))
        stable_err <= 1'b1;
      if (m_valid && m_wstrb != 4'h0 && m_wstrb != 4'hF) stable_err <= 1'b1;
      prev_pend <= m_valid && !m_ready;
      prev_a <= m_addr;
      prev_d <= m_wdata;
      prev_s <= m_wstrb;
      if (m_valid && !m_ready && !(m_wstrb == 4'h0 && rd_acks == stall_at)) begin
        if (wait_cnt >= cur_lat) begin
          m_ready  <= 1'b1;
          wait_cnt <= 0;
          cur_lat  <= int'($urandom_range(lat_max, 0));
          m_rdata  <= mem[m_addr[11:2]];
          if (m_wstrb == 4'hF) begin
            mem[m_addr[11:2]] <= m_wdata;
            wr_addr_q.push_back(m_addr);
            wr_data_q.push_back(m_wdata);
          end else begin
            rd_acks <= rd_acks + 1;
          end
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end else begin
        m_ready <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cpu_access(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d,
                            output logic [31:0] rd);
    int n;
    rd = '0;
    dma_sel = 1'b1;
    addr = a;
    wstrb = s;
    dma_data_i = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!dma_ready && n < 8);
    check("slave_ready", {31'b0, dma_ready}, 32'd1);
    rd = dma_data_o;
    @(posedge clk); #1;
    dma_sel = 1'b0;
    wstrb = 4'h0;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] unused;
    cpu_access(a, 4'hF, d, unused);
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
    cpu_access(a, 4'h0, '0, d);
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cpu_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_irq(input string tag, input int budget, output int n);
    n = 0;
    while (!irq && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {31'b0, irq}, 32'd1);
  endtask

  // Reference copy: word i of the source lands at dst+4i, in order.
  task automatic expect_copy(input string tag, input int base, input logic [31:0] dst,
                             input logic [31:0] exp_data[$]);
    check({tag, "_count"}, 32'(wr_addr_q.size() - base), 32'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && base + i < wr_addr_q.size(); i++) begin
      check({tag, "_addr"}, wr_addr_q[base + i], dst + 32'(4 * i));
      check({tag, "_data"}, wr_data_q[base + i], exp_data[i]);
    end
  endtask

  task automatic snapshot(input logic [31:0] src, input int n, output logic [31:0] q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(mem[10'((src >> 2) + 32'(i))]);
  endtask

  initial begin
    logic [31:0] exp_q[$];
    int n;
    int base;
    int v0;

    seed = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wstrb", {28'b0, m_wstrb}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_dma_ready", {31'b0, dma_ready}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    read_check("rst_src", 4'h0, 32'd0);
    read_check("rst_len", 4'h8, 32'd0);
    read_check("rst_status", 4'hC, 32'd0);

    // 1: four-word copy at single-cycle latency
    snapshot(32'h100, 4, exp_q);
    base = wr_addr_q.size();
    cpu_write(4'h0, 32'h100);
    cpu_write(4'h4, 32'h200);
    cpu_write(4'h8, 32'd4);
    cpu_write(4'hC, 32'h1);
    wait_irq("t1_irq", 200, n);
    check("t1_cycles", 32'(n), 32'd24);
    expect_copy("t1_wr", base, 32'h200, exp_q);
    read_check("t1_status", 4'hC, 32'h2);
    read_check("t1_src", 4'h0, 32'h110);
    read_check("t1_dst", 4'h4, 32'h210);
    read_check("t1_len", 4'h8, 32'd0);

    // 2: zero length finishes immediately without bus traffic
    v0 = vcyc;
    cpu_write(4'h8, 32'd0);
    cpu_write(4'hC, 32'h1);
    check("t2_irq_now", {31'b0, irq}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("t2_no_valid", 32'(vcyc - v0), 32'd0);
    read_check("t2_status", 4'hC, 32'h2);

    // 3: second read never acknowledged -> timeout after 16 cycles
    stall_at = rd_acks + 1;
    base = wr_addr_q.size();
    cpu_write(4'h0, 32'h100);
    cpu_write(4'h4, 32'h200);
    cpu_write(4'h8, 32'd4);
    cpu_write(4'hC, 32'h1);
    wait_irq("t3_irq", 200, n);
    @(posedge clk); #1;
    stall_at = -1;
    check("t3_valid_run", 32'(last_run), 32'd16);
    check("t3_valid_low", {31'b0, m_valid}, 32'd0);
    check("t3_writes", 32'(wr_addr_q.size() - base), 32'd1);
    read_check("t3_status", 4'hC, 32'h6);
    read_check("t3_src", 4'h0, 32'h104);
    read_check("t3_dst", 4'h4, 32'h204);
    read_check("t3_len", 4'h8, 32'd3);

    // 4: reconfiguration while busy is ignored, clear is still accepted
    snapshot(32'h800, 8, exp_q);
    base = wr_addr_q.size();
    cpu_write(4'h0, 32'h800);
    cpu_write(4'h4, 32'h900);
    cpu_write(4'h8, 32'd8);
    cpu_write(4'hC, 32'h1);
    cpu_write(4'h4, 32'h300);
    cpu_write(4'hC, 32'h1);
    cpu_write(4'hC, 32'h2);
    read_check("t4_status_busy", 4'hC, 32'h1);
    wait_irq("t4_irq", 400, n);
    expect_copy("t4_wr", base, 32'h900, exp_q);
    read_check("t4_dst", 4'h4, 32'h920);
    cpu_write(4'hC, 32'h2);
    check("t4_irq_clear", {31'b0, irq}, 32'd0);

    // 5: reset pulse during a write request
    cpu_write(4'h0, 32'hA00);
    cpu_write(4'h4, 32'hB00);
    cpu_write(4'h8, 32'd4);
    cpu_write(4'hC, 32'h1);
    n = 0;
    while (!(m_valid && m_wstrb == 4'hF) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_saw_wr_req", {31'b0, m_valid}, 32'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("t5_valid", {31'b0, m_valid}, 32'd0);
    check("t5_irq", {31'b0, irq}, 32'd0);
    v0 = vcyc;
    repeat (20) @(posedge clk);
    #1;
    check("t5_no_traffic", 32'(vcyc - v0), 32'd0);
    read_check("t5_src", 4'h0, 32'd0);
    read_check("t5_dst", 4'h4, 32'd0);
    read_check("t5_len", 4'h8, 32'd0);
    read_check("t5_status", 4'hC, 32'd0);

    // 6: random ready latency, misaligned source rounds down to 0x0
    lat_max = 5;
    snapshot(32'h0, 32, exp_q);
    base = wr_addr_q.size();
    cpu_write(4'h0, 32'h3);
    cpu_write(4'h4, 32'h400);
    cpu_write(4'h8, 32'd32);
    cpu_write(4'hC, 32'h1);
    wait_irq("t6_irq", 2000, n);
    expect_copy("t6_wr", base, 32'h400, exp_q);
    read_check("t6_src", 4'h0, 32'h80);
    read_check("t6_dst", 4'h4, 32'h480);
    read_check("t6_status", 4'hC, 32'h2);
    check("t6_stable", {31'b0, stable_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
